grf_mp: RTL and testbench
=========================

Name: grf_mp

Overview:
- Parametrised successor to the single-write general register file used by the pipelined CPU.
- Provides NR combinational read ports and NW write ports with write-through bypass.
- Adds a per-register scoreboard of pending-write bits. The decode stage uses it to detect RAW hazards without recomputing Tuse/Tnew.
- Sits between the D stage (read, issue) and the W stage (write, retire).

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers; must be a power of 2.
- AW, $clog2(NREG), register address width (derived; not overridable).
- NR, 2, number of read ports.
- NW, 1, number of write ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and issue.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NR*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NR*DW  packed read data.
- rd_pending  out  NR  scoreboard bit of each read address, after bypass.
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*AW  packed write addresses.
- wr_data  in  NW*DW  packed write data.
- wr_pc  in  NW*32  PC of the retiring instruction, per write port.
- iss_en  in  1  mark a register as having a pending write.
- iss_addr  in  AW  register being marked pending.
- busy_any  out  1  OR of all pending bits.

Behaviour:
- Reset:
  - On a rising clk with reset=1, all NREG registers become 0 and all pending bits clear, in one cycle.
  - reset overrides any simultaneous write or issue.
  - After reset: rd_data=0, rd_pending=0, busy_any=0.
- Write:
  - On a rising clk, for every port w with wr_en[w]=1 and a writable address, the register at wr_addr[w] takes wr_data[w].
  - With ZERO_REG=1, address 0 is not writable.
  - If two ports target the same address in the same cycle, the highest-index port wins.
- Read:
  - Combinational.
  - If rd_addr[i] matches any enabled writable wr_addr[w], rd_data[i] = wr_data of the highest matching w (same-cycle bypass).
  - Otherwise rd_data[i] is the stored value.
  - With ZERO_REG=1, address 0 always returns 0 and is never bypassed.
- Scoreboard, per register r, updated on each rising clk:
  - clear when any enabled write targets r;
  - set when iss_en=1 and iss_addr=r;
  - set and clear in the same cycle on the same r: set wins, because the newer producer is still outstanding.
  - With ZERO_REG=1, pending[0] is always 0.
- rd_pending[i]:
  - equals pending[rd_addr[i]];
  - forced to 0 when a same-cycle enabled write targets that address (bypass makes the data valid);
  - no bypass from iss_en into rd_pending; it takes effect the next cycle.
- busy_any is registered-state derived (OR of pending bits) and has no combinational path from inputs.
- Latency:
  - write to storage: 1 cycle;
  - write to read data: 0 cycles via bypass;
  - issue to pending visible: 1 cycle.
- Reset mid-operation: pending writes are lost and all pending bits are cleared. The pipeline flush is the caller's responsibility.

Optional Feature:
- Macro: CPU_GRF_TRACE_EN.
- When defined:
  - On every rising clk where a write commits (not under reset, writable address), the block emits a simulation $display line "@<pc>: $<reg> <= <data>", one per committed port, in ascending port order.
  - A losing port in a same-address conflict is not printed.
  - Adds output trace_valid (1 bit, registered) and trace_pc (32 bits, registered): the PC of the highest-index committed write in the previous cycle. Both are 0 after reset.
- When undefined: no display, no trace ports, no trace registers.

Decomposition:
- Package grf_pkg holds:
  - function clog2;
  - localparams for the default DW and NREG;
  - enum-style constants for the trace format;
  - a helper function prio_match(addr, wr_en, wr_addr) returning the winning port index and a hit flag.
- The helper is shared by the write and bypass logic.
- One sub-module, grf_scoreboard: NREG pending bits with set/clear priority, rd_pending lookup and busy_any.
- The storage array and bypass stay in grf_mp.

Test Plan:
- Reset then read: reset=1 for 2 cycles, then release; read addresses 1..31 -> all rd_data=0, busy_any=0.
- Write then read:
  - NW=1: write $5<=0x1234_5678; next cycle read $5 -> 0x1234_5678.
  - Read $5 in the same cycle as the write -> 0x1234_5678 (bypass).
  - Write to $0 -> read $0 = 0.
- Dual-write conflict: NW=2, both ports write $7 with 0xAAAA and 0xBBBB -> $7=0xBBBB. Same-cycle read of $7 -> 0xBBBB.
- Scoreboard sequence:
  - iss $9 -> next cycle rd_pending=1, busy_any=1.
  - write $9 -> that cycle rd_pending=0 via bypass; next cycle pending clear, busy_any=0.
  - iss $9 and write $9 in the same cycle -> pending stays 1.
- Reset mid-operation: pending on $3 and $4, then write $3=0x55 together with reset=1 -> $3=0, all pending 0.
- Trace (CPU_GRF_TRACE_EN): write $2<=0x10 at pc 0x3000 -> display "@00003000: $ 2 <= 00000010"; next cycle trace_valid=1, trace_pc=0x3000.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and helpers for the multi-port register file: port-priority match, clog2, trace field ids.
// Only pure functions and constants; no state.
package grf_pkg;

    localparam int DEFAULT_DW   = 32;
    localparam int DEFAULT_NREG = 32;
    localparam int MAX_NW       = 4;
    localparam int MAX_AW       = 8;
    localparam int TRC_PC_W     = 32;

    typedef enum logic [1:0] {
        TRC_FLD_PC   = 2'd0,
        TRC_FLD_REG  = 2'd1,
        TRC_FLD_DATA = 2'd2
    } trc_fld_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } prio_t;

    function automatic int clog2(input int n);
        int r = 0;
        int v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Ascending scan so the highest-index enabled port targeting addr wins.
    function automatic prio_t prio_match(input logic [MAX_AW-1:0]        addr,
                                         input logic [MAX_NW-1:0]        wr_en,
                                         input logic [MAX_NW*MAX_AW-1:0] wr_addr);
        prio_t res;
        res.hit = 1'b0;
        res.idx = 2'd0;
        for (int w = 0; w < MAX_NW; w++) begin
            if (wr_en[w] && (wr_addr[w*MAX_AW +: MAX_AW] == addr)) begin
                res.hit = 1'b1;
                res.idx = 2'(w);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grf_mp_if.sv
// Decode/writeback bundle of the register file: read ports, write ports, issue marking, scoreboard status.
// master = pipeline side, slave = register file.
interface grf_mp_if #(
    parameter int DW   = grf_pkg::DEFAULT_DW,
    parameter int NREG = grf_pkg::DEFAULT_NREG,
    parameter int NR   = 2,
    parameter int NW   = 1
);
    localparam int AW = grf_pkg::clog2(NREG);

    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_pending;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic [NW*32-1:0] wr_pc;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        input  rd_data, rd_pending, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        output rd_data, rd_pending, busy_any
    );
endinterface

// File: rtl/grf_scoreboard.sv
// Pending-write bit per register: issue sets, retiring write clears, issue wins a tie.
// Latency: issue visible next cycle; lookup combinational. No backpressure.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int NREG     = DEFAULT_NREG,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREG-1:0]  clr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR-1:0]    rd_pending,
    output logic             busy_any
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] set_v;

    always_comb begin
        set_v = '0;
        if (iss_en) set_v[iss_addr] = 1'b1;
        pend_nxt = (pend & ~clr) | set_v;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= pend_nxt;
    end

    // A same-cycle write bypasses its data, so that read is no longer waiting.
    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < NR; i++) begin
            rd_pending[i] = pend[rd_addr[i*AW +: AW]] & ~clr[rd_addr[i*AW +: AW]];
        end
    end

    assign busy_any = |pend;

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with write-through bypass and pending-write scoreboard; trace via CPU_GRF_TRACE_EN.
// Latency: write->storage 1 cycle, write->read 0 cycles (bypass), issue->pending 1 cycle. No backpressure.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int NREG     = DEFAULT_NREG,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    grf_mp_if.slave     bus
`ifdef CPU_GRF_TRACE_EN
    ,
    output logic        trace_valid,
    output logic [31:0] trace_pc
`endif
);

    localparam int AW = clog2(NREG);

    logic [DW-1:0]              regs [NREG];
    logic [MAX_NW-1:0]          en_pad;
    logic [MAX_NW*MAX_AW-1:0]   addr_pad;
    prio_t                      win [NREG];
    logic [NREG-1:0]            wr_hit;

    // Writes to the hardwired zero register are dropped before matching.
    always_comb begin
        en_pad   = '0;
        addr_pad = '0;
        for (int w = 0; w < NW; w++) begin
            addr_pad[w*MAX_AW +: MAX_AW] = MAX_AW'(bus.wr_addr[w*AW +: AW]);
            en_pad[w] = bus.wr_en[w] && !((ZERO_REG != 0) && (bus.wr_addr[w*AW +: AW] == '0));
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            win[r]    = prio_match(MAX_AW'(r), en_pad, addr_pad);
            wr_hit[r] = win[r].hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (win[r].hit) regs[r] <= bus.wr_data[int'(win[r].idx)*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NR; i++) begin
            if ((ZERO_REG != 0) && (bus.rd_addr[i*AW +: AW] == '0))
                bus.rd_data[i*DW +: DW] = '0;
            else if (win[bus.rd_addr[i*AW +: AW]].hit)
                bus.rd_data[i*DW +: DW] = bus.wr_data[int'(win[bus.rd_addr[i*AW +: AW]].idx)*DW +: DW];
            else
                bus.rd_data[i*DW +: DW] = regs[bus.rd_addr[i*AW +: AW]];
        end
    end

    grf_scoreboard #(
        .NREG     (NREG),
        .NR       (NR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .clr        (wr_hit),
        .iss_en     (bus.iss_en),
        .iss_addr   (bus.iss_addr),
        .rd_addr    (bus.rd_addr),
        .rd_pending (bus.rd_pending),
        .busy_any   (bus.busy_any)
    );

`ifdef CPU_GRF_TRACE_EN
    logic [NW-1:0]       commit;
    logic                trc_any;
    logic [TRC_PC_W-1:0] trc_pc_nxt;

    // A port commits only if it is the winner for its own address.
    always_comb begin
        commit     = '0;
        trc_any    = 1'b0;
        trc_pc_nxt = trace_pc;
        for (int w = 0; w < NW; w++) begin
            if (en_pad[w] && (int'(win[bus.wr_addr[w*AW +: AW]].idx) == w)) begin
                commit[w]  = 1'b1;
                trc_any    = 1'b1;
                trc_pc_nxt = bus.wr_pc[w*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
        end else begin
            trace_valid <= trc_any;
            if (trc_any) trace_pc <= trc_pc_nxt;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NW; w++) begin
                if (commit[w])
                    $display("@%h: $%d <= %h", bus.wr_pc[w*32 +: 32],
                             bus.wr_addr[w*AW +: AW], bus.wr_data[w*DW +: DW]);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.wr_pc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp (NR=2, NW=2, ZERO_REG=1): directed vector table plus random traffic against a reference model.
module tb_grf_mp;

    logic clk;
    logic reset;

    grf_mp_if #(.DW(32), .NREG(32), .NR(2), .NW(2)) bus ();

`ifdef CPU_GRF_TRACE_EN
    logic        trace_valid;
    logic [31:0] trace_pc;
`endif

    grf_mp #(.DW(32), .NREG(32), .NR(2), .NW(2), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CPU_GRF_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // current stimulus
    bit        c_rst;
    bit [1:0]  c_we;
    bit [4:0]  c_wa [2];
    bit [31:0] c_wd [2];
    bit [31:0] c_pc [2];
    bit        c_ie;
    bit [4:0]  c_ia;
    bit [4:0]  c_ra [2];

    // reference model state
    bit [31:0] m_mem  [32];
    bit        m_pend [32];
    bit        m_tv;
    bit [31:0] m_tpc;

    typedef struct {
        bit        rst;
        bit [1:0]  we;
        bit [4:0]  wa0, wa1;
        bit [31:0] wd0, wd1;
        bit        ie;
        bit [4:0]  ia;
        bit [4:0]  ra0, ra1;
        bit        chk;
        bit [31:0] ed0, ed1;
        bit [1:0]  ep;
        bit        eb;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic apply();
        reset        = c_rst;
        bus.wr_en    = c_we;
        bus.wr_addr  = {c_wa[1], c_wa[0]};
        bus.wr_data  = {c_wd[1], c_wd[0]};
        bus.wr_pc    = {c_pc[1], c_pc[0]};
        bus.iss_en   = c_ie;
        bus.iss_addr = c_ia;
        bus.rd_addr  = {c_ra[1], c_ra[0]};
    endtask

    task automatic idle();
        c_rst = 1'b0;
        c_we  = 2'b00;
        c_ie  = 1'b0;
    endtask

    // Architectural effect of one rising edge on the model.
    task automatic model_edge();
        bit        any;
        bit [31:0] last_pc;
        any = 1'b0;
        last_pc = 32'h0;
        if (c_rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'h0;
                m_pend[r] = 1'b0;
            end
            m_tv  = 1'b0;
            m_tpc = 32'h0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (c_we[w] && c_wa[w] != 5'd0) begin
                    m_mem[c_wa[w]]  = c_wd[w];
                    m_pend[c_wa[w]] = 1'b0;
                    any = 1'b1;
                    last_pc = c_pc[w];
                end
            end
            if (c_ie && c_ia != 5'd0) m_pend[c_ia] = 1'b1;
            m_tv = any;
            if (any) m_tpc = last_pc;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        bit [31:0] ed;
        bit        ep;
        bit        eb;
        for (int i = 0; i < 2; i++) begin
            ed = m_mem[c_ra[i]];
            ep = m_pend[c_ra[i]];
            for (int w = 0; w < 2; w++) begin
                if (c_we[w] && c_wa[w] == c_ra[i] && c_ra[i] != 5'd0) begin
                    ed = c_wd[w];
                    ep = 1'b0;
                end
            end
            if (c_ra[i] == 5'd0) ed = 32'h0;
            chk($sformatf("%s rd_data%0d", tag, i), bus.rd_data[i*32 +: 32], ed);
            chk($sformatf("%s rd_pending%0d", tag, i), 32'(bus.rd_pending[i]), 32'(ep));
        end
        eb = 1'b0;
        for (int r = 0; r < 32; r++) eb |= m_pend[r];
        chk($sformatf("%s busy_any", tag), 32'(bus.busy_any), 32'(eb));
`ifdef CPU_GRF_TRACE_EN
        chk($sformatf("%s trace_valid", tag), 32'(trace_valid), 32'(m_tv));
        chk($sformatf("%s trace_pc", tag), trace_pc, m_tpc);
`endif
    endtask

    initial begin
        vecs[0]  = '{0, 2'b01, 5, 0, 32'h12345678, 0, 0, 0, 5, 0, 1, 32'h12345678, 0, 2'b00, 0};
        vecs[1]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 1, 32'h12345678, 32'h12345678, 2'b00, 0};
        vecs[2]  = '{0, 2'b01, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 5, 1, 0, 32'h12345678, 2'b00, 0};
        vecs[3]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 32'h12345678, 2'b00, 0};
        vecs[4]  = '{0, 2'b11, 7, 7, 32'hAAAA, 32'hBBBB, 0, 0, 7, 7, 1, 32'hBBBB, 32'hBBBB, 2'b00, 0};
        vecs[5]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 5, 1, 32'hBBBB, 32'h12345678, 2'b00, 0};
        vecs[6]  = '{0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 9, 1, 0, 0, 2'b00, 0};
        vecs[7]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0, 2'b11, 1};
        vecs[8]  = '{0, 2'b01, 9, 0, 32'h99, 0, 0, 0, 9, 5, 1, 32'h99, 32'h12345678, 2'b00, 1};
        vecs[9]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 5, 1, 32'h99, 32'h12345678, 2'b00, 0};
        vecs[10] = '{0, 2'b10, 0, 9, 0, 32'h77, 1, 9, 9, 9, 1, 32'h77, 32'h77, 2'b00, 0};
        vecs[11] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 1, 32'h77, 32'h77, 2'b11, 1};
        vecs[12] = '{0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 4, 1, 0, 0, 2'b00, 1};
        vecs[13] = '{0, 2'b00, 0, 0, 0, 0, 1, 4, 3, 4, 1, 0, 0, 2'b01, 1};
        vecs[14] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 1, 0, 0, 2'b11, 1};
        vecs[15] = '{1, 2'b01, 3, 0, 32'h55, 0, 0, 0, 3, 4, 0, 0, 0, 2'b00, 0};
        vecs[16] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 4, 1, 0, 0, 2'b00, 0};
        vecs[17] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 7, 1, 0, 0, 2'b00, 0};
        vecs[18] = '{0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0};
        vecs[19] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0};

        // reset held for two cycles
        for (int w = 0; w < 2; w++) begin
            c_wa[w] = 5'd0; c_wd[w] = 32'h0; c_pc[w] = 32'h0; c_ra[w] = 5'd0;
        end
        c_ia = 5'd0;
        idle();
        c_rst = 1'b1;
        apply();
        cycle();
        cycle();
        idle();

        for (int a = 1; a < 32; a++) begin
            c_ra[0] = 5'(a);
            c_ra[1] = 5'(32 - a);
            apply();
            #1;
            chk($sformatf("reset rd_data0 a=%0d", a), bus.rd_data[31:0], 32'h0);
            chk($sformatf("reset rd_data1 a=%0d", a), bus.rd_data[63:32], 32'h0);
            chk($sformatf("reset busy a=%0d", a), 32'(bus.busy_any), 32'h0);
            cycle();
        end

        for (int r = 0; r < 20; r++) begin
            c_rst   = vecs[r].rst;
            c_we    = vecs[r].we;
            c_wa[0] = vecs[r].wa0;  c_wa[1] = vecs[r].wa1;
            c_wd[0] = vecs[r].wd0;  c_wd[1] = vecs[r].wd1;
            c_pc[0] = 32'h3000 + 32'(r * 16);
            c_pc[1] = 32'h3000 + 32'(r * 16 + 1);
            c_ie    = vecs[r].ie;
            c_ia    = vecs[r].ia;
            c_ra[0] = vecs[r].ra0;  c_ra[1] = vecs[r].ra1;
            apply();
            #1;
            if (vecs[r].chk) begin
                chk($sformatf("vec%0d rd_data0", r), bus.rd_data[31:0], vecs[r].ed0);
                chk($sformatf("vec%0d rd_data1", r), bus.rd_data[63:32], vecs[r].ed1);
                chk($sformatf("vec%0d rd_pending", r), 32'(bus.rd_pending), 32'(vecs[r].ep));
                chk($sformatf("vec%0d busy_any", r), 32'(bus.busy_any), 32'(vecs[r].eb));
            end
            cycle();
        end

`ifdef CPU_GRF_TRACE_EN
        idle();
        c_we = 2'b01; c_wa[0] = 5'd2; c_wd[0] = 32'h10; c_pc[0] = 32'h3000;
        c_ra[0] = 5'd2; c_ra[1] = 5'd0;
        apply();
        cycle();
        idle();
        apply();
        #1;
        chk("trace valid after $2 write", 32'(trace_valid), 32'h1);
        chk("trace pc after $2 write", trace_pc, 32'h3000);
        chk("trace $2 stored", bus.rd_data[31:0], 32'h10);
        cycle();
`endif

        // random traffic, addresses mostly in a small window to force conflicts
        for (int n = 0; n < 400; n++) begin
            c_rst = ($urandom_range(0, 49) == 0);
            c_we  = 2'($urandom);
            for (int w = 0; w < 2; w++) begin
                c_wa[w] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                c_wd[w] = $urandom;
                c_pc[w] = $urandom;
                c_ra[w] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            end
            c_ie = 1'($urandom);
            c_ia = 5'($urandom_range(0, 7));
            apply();
            #1;
            if (!c_rst) check_model($sformatf("rand%0d", n));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
